fetch_decode_buffer: RTL and testbench
======================================

# fetch_decode_buffer

Pipeline register on the consuming end of the fetch stage's 64-bit output bus. It latches each fetched word into the decode side and reassembles two-word instructions (instruction plus 16-bit immediate) into one decode packet. It applies stall and flush from the hazard and jump logic, and presents a registered, valid-qualified packet to the decode stage.

## Interface
Parameters:
- `IMM_BIT`, 15: bit of the fetched instruction word that marks a two-word instruction (1 means the next fetched word is its immediate).
- `CNT_W`, 16: width of the issued-instruction counter.

Ports:
- `Clk`  input  1  pipeline clock; all state updates on the rising edge.
- `Rst`  input  1  synchronous, active-high reset.
- `In`  input  64  fetch output bus:
  - `In[63:48]` side-band field
  - `In[47:16]` next PC (PC of fetched word + 1)
  - `In[15:0]` fetched 16-bit word
- `Stall`  input  1  hold everything this cycle.
- `Flush`  input  1  discard the current and pending word (taken jump, RET/RTI, interrupt).
- `Valid`  output  1  decode packet is a real instruction; 0 means bubble.
- `Inst`  output  16  instruction word.
- `Imm`  output  16  immediate; 0 for single-word instructions.
- `PcNext`  output  32  next-PC value for the packet. For two-word instructions this is the value that arrived with the immediate word.
- `Side`  output  16  side-band field travelling with the instruction word.
- `ImmPending`  output  1  1 while in state IMM (waiting for the immediate word).
- `IssueCnt`  output  `CNT_W`  count of packets issued with `Valid`=1, wrapping modulo 2^`CNT_W`.

## Operation
- Priority on each rising edge: `Rst` > `Flush` > `Stall` > normal capture.
- Reset:
  - `Valid`=0; `Inst`, `Imm`, `PcNext`, `Side` = 0; `ImmPending`=0; `IssueCnt`=0.
  - State = NORMAL; internal holding registers cleared.
- FSM states: NORMAL, IMM.
- NORMAL, word with `In[IMM_BIT]`=0:
  - `Inst`=`In[15:0]`, `Imm`=0, `PcNext`=`In[47:16]`, `Side`=`In[63:48]`, `Valid`=1.
  - `IssueCnt`+1; stay in NORMAL.
- NORMAL, word with `In[IMM_BIT]`=1:
  - Copy `In[15:0]` and `In[63:48]` into holding registers.
  - Outputs become a bubble: `Valid`=0; `Inst`, `Imm`, `PcNext`, `Side` = 0.
  - Go to IMM.
- IMM (any incoming word, treated as the immediate; its `IMM_BIT` is ignored):
  - `Inst`=held word, `Side`=held side-band, `Imm`=`In[15:0]`, `PcNext`=`In[47:16]`, `Valid`=1.
  - `IssueCnt`+1; go to NORMAL.
- `Flush`, in any state:
  - Outputs become a bubble (`Valid`=0, data fields 0).
  - Holding registers cleared, state = NORMAL, `IssueCnt` unchanged.
- `Stall`, without `Flush`: all outputs, holding registers, state and `IssueCnt` keep their values. The stall is transparent to partial two-word assembly.
- `ImmPending` is a registered decode of state (1 exactly when state = IMM).
- `IssueCnt` wraps from 2^`CNT_W`-1 to 0 with no flag.

## Timing
- Latency: 1 cycle from a word on `In` to its packet on the outputs (single-word instructions).
- Two-word instructions: a bubble the cycle after the first word, then the full packet the cycle after the immediate word. That is 2 cycles from the first word; the immediate's cycle yields no extra bubble.
- `Stall` and `Flush` are sampled at the same edge as `In`. A word on `In` during a `Stall` or `Flush` cycle is never captured.
- `Flush` and `Stall` high together: the flush behaviour applies.
- `Flush` in IMM: the held first word is dropped; the following word is decoded fresh in NORMAL.
- `Rst` mid-assembly: identical to the reset values above; no partial packet is emitted afterwards.
- No combinational path from inputs to outputs; all outputs are flops.

## Test plan
- Reset: hold `Rst` 2 cycles with `In`=all ones → all outputs 0, `ImmPending`=0; first edge after release with `In`={16'hAAAA, 32'h1, 16'h1234} → `Valid`=1, `Inst`=16'h1234, `PcNext`=1, `Side`=16'hAAAA, `IssueCnt`=1.
- Two-word instruction: `In[15:0]`=16'h8001, then `In`={16'h0, 32'h6, 16'h00FF} → first cycle `Valid`=0 and `ImmPending`=1; next cycle `Inst`=16'h8001, `Imm`=16'h00FF, `PcNext`=6, `ImmPending`=0.
- Stall in IMM: after word 16'h8001, hold `Stall` 3 cycles → outputs frozen as a bubble with `ImmPending`=1; then immediate 16'h0042 → `Inst`=16'h8001, `Imm`=16'h0042.
- Flush in IMM together with `Stall`: word 16'h8001, then `Flush`=1 and `Stall`=1 → `Valid`=0, `ImmPending`=0; next word 16'h0005 → `Inst`=16'h0005, `Imm`=0, `Valid`=1.
- Counter wrap with `CNT_W`=4: issue 17 single-word instructions → `IssueCnt` goes 15 → 0 → 1; bubbles and flushes do not increment it.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// Decode-side pipeline register for the fetch bus. It joins an instruction word
// and its 16-bit immediate into one registered, valid-qualified decode packet.
module fetch_decode_buffer #(
   parameter int IMM_BIT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [63:0]      In,
   input  logic             Stall,
   input  logic             Flush,
   output logic             Valid,
   output logic [15:0]      Inst,
   output logic [15:0]      Imm,
   output logic [31:0]      PcNext,
   output logic [15:0]      Side,
   output logic             ImmPending,
   output logic [CNT_W-1:0] IssueCnt
);

   typedef enum logic {NORMAL = 1'b0, IMM = 1'b1} state_t;

   typedef struct packed {
      logic        valid;
      logic [15:0] inst;
      logic [15:0] imm;
      logic [31:0] pc_next;
      logic [15:0] side;
   } pkt_t;

   state_t           state_q, state_d;
   pkt_t             pkt_q, pkt_d;
   logic [15:0]      hold_word_q, hold_word_d;
   logic [15:0]      hold_side_q, hold_side_d;
   logic             pend_q;
   logic [CNT_W-1:0] cnt_q;
   logic             capture, issue;

   assign capture = !Flush && !Stall;
   // A packet leaves this stage when an immediate completes a pair, or a single-word op arrives.
   assign issue   = capture && (state_q == IMM || !In[IMM_BIT]);

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state_q <= NORMAL;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (Flush)
         state_d = NORMAL;
      else if (!Stall) begin
         case (state_q)
            NORMAL:  state_d = In[IMM_BIT] ? IMM : NORMAL;
            IMM:     state_d = NORMAL;
            default: state_d = NORMAL;
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      pkt_d       = pkt_q;
      hold_word_d = hold_word_q;
      hold_side_d = hold_side_q;
      if (Flush) begin
         pkt_d       = '0;
         hold_word_d = '0;
         hold_side_d = '0;
      end else if (!Stall) begin
         case (state_q)
            NORMAL: begin
               if (In[IMM_BIT]) begin
                  pkt_d       = '0;
                  hold_word_d = In[15:0];
                  hold_side_d = In[63:48];
               end else begin
                  pkt_d.valid   = 1'b1;
                  pkt_d.inst    = In[15:0];
                  pkt_d.imm     = 16'h0;
                  pkt_d.pc_next = In[47:16];
                  pkt_d.side    = In[63:48];
               end
            end
            IMM: begin
               // Incoming word is the immediate regardless of its own IMM_BIT.
               pkt_d.valid   = 1'b1;
               pkt_d.inst    = hold_word_q;
               pkt_d.imm     = In[15:0];
               pkt_d.pc_next = In[47:16];
               pkt_d.side    = hold_side_q;
               hold_word_d   = '0;
               hold_side_d   = '0;
            end
            default: pkt_d = '0;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pkt_q       <= '0;
         hold_word_q <= '0;
         hold_side_q <= '0;
         pend_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         pkt_q       <= pkt_d;
         hold_word_q <= hold_word_d;
         hold_side_q <= hold_side_d;
         pend_q      <= (state_d == IMM);
         if (issue) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign Valid      = pkt_q.valid;
   assign Inst       = pkt_q.inst;
   assign Imm        = pkt_q.imm;
   assign PcNext     = pkt_q.pc_next;
   assign Side       = pkt_q.side;
   assign ImmPending = pend_q;
   assign IssueCnt   = cnt_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
module tb_fetch_decode_buffer;

   localparam int CNT_W = 4;

   logic             Clk = 1'b0;
   logic             Rst, Stall, Flush;
   logic [63:0]      In;
   logic             Valid, ImmPending;
   logic [15:0]      Inst, Imm, Side;
   logic [31:0]      PcNext;
   logic [CNT_W-1:0] IssueCnt;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_decode_buffer #(.IMM_BIT(15), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst), .In(In), .Stall(Stall), .Flush(Flush),
      .Valid(Valid), .Inst(Inst), .Imm(Imm), .PcNext(PcNext), .Side(Side),
      .ImmPending(ImmPending), .IssueCnt(IssueCnt)
   );

   always #5 Clk = ~Clk;

   // Reference model: what decode should see after each edge.
   logic        m_valid, m_pend;
   logic [15:0] m_inst, m_imm, m_side, m_hword, m_hside;
   logic [31:0] m_pc;
   int          m_cnt;

   task automatic model_step(input logic rst, input logic [63:0] w, input logic stall, input logic flush);
      if (rst) begin
         {m_valid, m_pend, m_inst, m_imm, m_side, m_pc, m_hword, m_hside} = '0;
         m_cnt = 0;
      end else if (flush) begin
         {m_valid, m_inst, m_imm, m_side, m_pc} = '0;
         m_pend = 0;
      end else if (!stall) begin
         if (m_pend) begin
            m_valid = 1; m_inst = m_hword; m_side = m_hside;
            m_imm = w[15:0]; m_pc = w[47:16];
            m_pend = 0; m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end else if (w[15]) begin
            m_hword = w[15:0]; m_hside = w[63:48];
            {m_valid, m_inst, m_imm, m_side, m_pc} = '0;
            m_pend = 1;
         end else begin
            m_valid = 1; m_inst = w[15:0]; m_imm = 0;
            m_pc = w[47:16]; m_side = w[63:48];
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end
      end
   endtask

   task automatic cycle(input logic rst, input logic [63:0] w, input logic stall, input logic flush);
      Rst = rst; In = w; Stall = stall; Flush = flush;
      @(posedge Clk);
      model_step(rst, w, stall, flush);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, '1, 0, 0);
      cycle(1, '1, 0, 0);
      n_checks++;
      if ({Valid, Inst, Imm, PcNext, Side, ImmPending, IssueCnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got V=%b I=%h M=%h P=%h S=%h IP=%b C=%0d, want all 0",
                  Valid, Inst, Imm, PcNext, Side, ImmPending, IssueCnt);
      end
      cycle(0, {16'hAAAA, 32'h1, 16'h1234}, 0, 0);
      n_checks++;
      if ({Valid, Inst, PcNext, Side, IssueCnt} !== {1'b1, 16'h1234, 32'h1, 16'hAAAA, 4'd1}) begin
         n_fail++;
         $display("FAIL first_after_reset: got V=%b I=%h P=%h S=%h C=%0d, want 1 1234 1 aaaa 1",
                  Valid, Inst, PcNext, Side, IssueCnt);
      end
   endtask

   task automatic test_two_word();
      cycle(0, {16'h0, 32'h5, 16'h8001}, 0, 0);
      n_checks++;
      if ({Valid, ImmPending} !== 2'b01) begin
         n_fail++;
         $display("FAIL two_word_bubble: got V=%b IP=%b, want 0 1", Valid, ImmPending);
      end
      cycle(0, {16'h0, 32'h6, 16'h00FF}, 0, 0);
      n_checks++;
      if ({Valid, Inst, Imm, PcNext, ImmPending} !== {1'b1, 16'h8001, 16'h00FF, 32'h6, 1'b0}) begin
         n_fail++;
         $display("FAIL two_word_packet: got V=%b I=%h M=%h P=%h IP=%b, want 1 8001 00ff 6 0",
                  Valid, Inst, Imm, PcNext, ImmPending);
      end
   endtask

   task automatic test_stall_imm();
      logic [CNT_W-1:0] c0;
      cycle(0, {16'h0, 32'h10, 16'h8001}, 0, 0);
      c0 = IssueCnt;
      for (int i = 0; i < 3; i++) begin
         cycle(0, {16'hFFFF, 32'hDEAD, 16'h0777}, 1, 0);
         n_checks++;
         if ({Valid, Inst, Imm, PcNext, Side, ImmPending, IssueCnt} !== {1'b0, 16'h0, 16'h0, 32'h0, 16'h0, 1'b1, c0}) begin
            n_fail++;
            $display("FAIL stall_imm_frozen[%0d]: got V=%b I=%h IP=%b C=%0d, want bubble IP=1 C=%0d",
                     i, Valid, Inst, ImmPending, IssueCnt, c0);
         end
      end
      cycle(0, {16'h0, 32'h12, 16'h0042}, 0, 0);
      n_checks++;
      if ({Valid, Inst, Imm} !== {1'b1, 16'h8001, 16'h0042}) begin
         n_fail++;
         $display("FAIL stall_imm_release: got V=%b I=%h M=%h, want 1 8001 0042", Valid, Inst, Imm);
      end
   endtask

   task automatic test_flush_stall_imm();
      cycle(0, {16'h0, 32'h20, 16'h8001}, 0, 0);
      cycle(0, {16'h0, 32'h21, 16'h0099}, 1, 1);
      n_checks++;
      if ({Valid, ImmPending} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_stall_imm: got V=%b IP=%b, want 0 0", Valid, ImmPending);
      end
      cycle(0, {16'h0, 32'h22, 16'h0005}, 0, 0);
      n_checks++;
      if ({Valid, Inst, Imm} !== {1'b1, 16'h0005, 16'h0}) begin
         n_fail++;
         $display("FAIL flush_then_fresh: got V=%b I=%h M=%h, want 1 0005 0000", Valid, Inst, Imm);
      end
   endtask

   task automatic test_counter_wrap();
      cycle(1, '0, 0, 0);
      for (int i = 1; i <= 17; i++) begin
         cycle(0, {16'h0, 32'(i), 16'(i)}, 0, 0);
         if (i >= 15) begin
            n_checks++;
            if (IssueCnt !== 4'(i % 16)) begin
               n_fail++;
               $display("FAIL cnt_wrap[%0d]: got %0d, want %0d", i, IssueCnt, i % 16);
            end
         end
      end
      cycle(0, {16'h0, 32'h1, 16'h8123}, 0, 0);
      cycle(0, {16'h0, 32'h2, 16'h0001}, 0, 1);
      cycle(0, {16'h0, 32'h3, 16'h0002}, 1, 0);
      n_checks++;
      if (IssueCnt !== 4'd1) begin
         n_fail++;
         $display("FAIL cnt_no_incr_bubble: got %0d, want 1", IssueCnt);
      end
   endtask

   task automatic test_random();
      logic [63:0] w;
      for (int i = 0; i < 400; i++) begin
         w = {$urandom, $urandom};
         cycle(($urandom_range(0, 49) == 0), w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
         n_checks++;
         if ({Valid, Inst, Imm, PcNext, Side, ImmPending, IssueCnt} !==
             {m_valid, m_inst, m_imm, m_pc, m_side, m_pend, 4'(m_cnt)}) begin
            n_fail++;
            $display("FAIL random[%0d]: got V=%b I=%h M=%h P=%h S=%h IP=%b C=%0d, want V=%b I=%h M=%h P=%h S=%h IP=%b C=%0d",
                     i, Valid, Inst, Imm, PcNext, Side, ImmPending, IssueCnt,
                     m_valid, m_inst, m_imm, m_pc, m_side, m_pend, m_cnt);
         end
      end
   endtask

   initial begin
      Rst = 1; In = '0; Stall = 0; Flush = 0;
      test_reset();
      test_two_word();
      test_stall_imm();
      test_flush_stall_imm();
      test_counter_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
